// File: rtl/regfile_rd_pkg.sv
// Shared types and constants for the register-file operand-fetch stage.
// Widths here are the defaults; the stage and snoop can be re-parameterized.
package regfile_rd_pkg;

   localparam int NR_RD_PORTS    = 2;
   localparam int NR_WB_PORTS    = 2;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 5;

   typedef logic [DEF_DATA_WIDTH-1:0] operand_t;

   typedef struct packed {
      logic                      we;
      logic [DEF_ADDR_WIDTH-1:0] waddr;
      operand_t                  wdata;
   } wb_port_t;

endpackage

// File: rtl/regfile_wb_snoop.sv
// Combinational write-back snoop for one operand: returns the operand value
// updated by this cycle's writes (port 1 wins), with register 0 pinned to zero.
module regfile_wb_snoop
   import regfile_rd_pkg::*;
#(
   parameter int  ADDR_WIDTH    = DEF_ADDR_WIDTH,
   parameter int  DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter bit  ZERO_REG_ZERO = 1'b1,
   parameter type wb_t          = wb_port_t
) (
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] cur,
   input  wb_t                   wb0,
   input  wb_t                   wb1,
   output logic                  hit,
   output logic [DATA_WIDTH-1:0] upd
);

   logic is_zero;
   logic hit0;
   logic hit1;

   assign is_zero = ZERO_REG_ZERO && (addr == '0);
   assign hit0    = wb0.we && (wb0.waddr == addr);
   assign hit1    = wb1.we && (wb1.waddr == addr);

   always_comb begin
      hit = 1'b0;
      upd = cur;
      if (is_zero) begin
         upd = '0;
      end else if (hit1) begin
         hit = 1'b1;
         upd = wb1.wdata;
      end else if (hit0) begin
         hit = 1'b1;
         upd = wb0.wdata;
      end
   end

endmodule

// File: rtl/regfile_read_stage.sv
// Operand-fetch stage behind a 1-cycle BRAM register file: S1 waits for the
// read, S2 is the output register; writes are forwarded into every stage.
module regfile_read_stage
   import regfile_rd_pkg::*;
#(
   parameter int  DATA_WIDTH    = 32,
   parameter int  NUM_WORDS     = 32,
   parameter bit  ZERO_REG_ZERO = 1'b1,
   parameter int  TAG_WIDTH     = 8,
   localparam int ADDR_WIDTH    = $clog2(NUM_WORDS)
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic                                   flush_i,
   input  logic                                   req_valid_i,
   output logic                                   req_ready_o,
   input  logic [NR_RD_PORTS-1:0][ADDR_WIDTH-1:0] req_raddr_i,
   input  logic [TAG_WIDTH-1:0]                   req_tag_i,
   output logic [NR_RD_PORTS-1:0][ADDR_WIDTH-1:0] rf_raddr_o,
   input  logic [NR_RD_PORTS-1:0][DATA_WIDTH-1:0] rf_rdata_i,
   input  logic [NR_WB_PORTS-1:0]                 wb_we_i,
   input  logic [NR_WB_PORTS-1:0][ADDR_WIDTH-1:0] wb_waddr_i,
   input  logic [NR_WB_PORTS-1:0][DATA_WIDTH-1:0] wb_wdata_i,
   output logic                                   out_valid_o,
   input  logic                                   out_ready_i,
   output logic [NR_RD_PORTS-1:0][DATA_WIDTH-1:0] out_data_o,
   output logic [TAG_WIDTH-1:0]                   out_tag_o
);

   typedef struct packed {
      logic                  we;
      logic [ADDR_WIDTH-1:0] waddr;
      logic [DATA_WIDTH-1:0] wdata;
   } wb_t;

   wb_t [NR_WB_PORTS-1:0] wb;

   // S1: read in flight
   logic                                   s1_valid;
   logic [NR_RD_PORTS-1:0][ADDR_WIDTH-1:0] s1_addr;
   logic [TAG_WIDTH-1:0]                   s1_tag;
   logic [NR_RD_PORTS-1:0]                 s1_fwd;
   logic [NR_RD_PORTS-1:0][DATA_WIDTH-1:0] s1_fwd_data;

   // S2: output register address copy for in-place forwarding
   logic [NR_RD_PORTS-1:0][ADDR_WIDTH-1:0] s2_addr;

   logic                                   s2_free;
   logic                                   s1_adv;
   logic                                   accept;
   logic                                   s2_stall;

   logic [NR_RD_PORTS-1:0]                 acc_hit;
   logic [NR_RD_PORTS-1:0][DATA_WIDTH-1:0] acc_val;
   logic [NR_RD_PORTS-1:0][DATA_WIDTH-1:0] s1_base;
   logic [NR_RD_PORTS-1:0]                 s1_hit;
   logic [NR_RD_PORTS-1:0][DATA_WIDTH-1:0] s1_op;
   logic [NR_RD_PORTS-1:0]                 s2_hit;
   logic [NR_RD_PORTS-1:0][DATA_WIDTH-1:0] s2_op;

   for (genvar p = 0; p < NR_WB_PORTS; p++) begin : g_wb
      assign wb[p] = {wb_we_i[p], wb_waddr_i[p], wb_wdata_i[p]};
   end

   assign s2_free     = !out_valid_o || out_ready_i;
   assign s1_adv      = s1_valid && s2_free;
   assign req_ready_o = !flush_i && (!s1_valid || s1_adv);
   assign accept      = req_valid_i && req_ready_o;
   assign s2_stall    = out_valid_o && !out_ready_i;
   assign rf_raddr_o  = req_raddr_i;

   for (genvar k = 0; k < NR_RD_PORTS; k++) begin : g_op
      // Accept cycle: the BRAM returns pre-write data on a collision
      regfile_wb_snoop #(
         .ADDR_WIDTH   (ADDR_WIDTH),
         .DATA_WIDTH   (DATA_WIDTH),
         .ZERO_REG_ZERO(ZERO_REG_ZERO),
         .wb_t         (wb_t)
      ) u_acc (
         .addr(req_raddr_i[k]),
         .cur ('0),
         .wb0 (wb[0]),
         .wb1 (wb[1]),
         .hit (acc_hit[k]),
         .upd (acc_val[k])
      );

      assign s1_base[k] = s1_fwd[k] ? s1_fwd_data[k] : rf_rdata_i[k];

      regfile_wb_snoop #(
         .ADDR_WIDTH   (ADDR_WIDTH),
         .DATA_WIDTH   (DATA_WIDTH),
         .ZERO_REG_ZERO(ZERO_REG_ZERO),
         .wb_t         (wb_t)
      ) u_s1 (
         .addr(s1_addr[k]),
         .cur (s1_base[k]),
         .wb0 (wb[0]),
         .wb1 (wb[1]),
         .hit (s1_hit[k]),
         .upd (s1_op[k])
      );

      regfile_wb_snoop #(
         .ADDR_WIDTH   (ADDR_WIDTH),
         .DATA_WIDTH   (DATA_WIDTH),
         .ZERO_REG_ZERO(ZERO_REG_ZERO),
         .wb_t         (wb_t)
      ) u_s2 (
         .addr(s2_addr[k]),
         .cur (out_data_o[k]),
         .wb0 (wb[0]),
         .wb1 (wb[1]),
         .hit (s2_hit[k]),
         .upd (s2_op[k])
      );
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid    <= 1'b0;
         s1_addr     <= '0;
         s1_tag      <= '0;
         s1_fwd      <= '0;
         s1_fwd_data <= '0;
      end else if (flush_i) begin
         s1_valid <= 1'b0;
      end else if (accept) begin
         s1_valid    <= 1'b1;
         s1_addr     <= req_raddr_i;
         s1_tag      <= req_tag_i;
         s1_fwd      <= acc_hit;
         s1_fwd_data <= acc_val;
      end else if (s1_adv) begin
         s1_valid <= 1'b0;
      end else if (s1_valid) begin
         // Stalled: rf_rdata_i is only good for one cycle, so latch the operand
         for (int k = 0; k < NR_RD_PORTS; k++) begin
            if (!s1_fwd[k] || s1_hit[k]) begin
               s1_fwd[k]      <= 1'b1;
               s1_fwd_data[k] <= s1_op[k];
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_valid_o <= 1'b0;
         out_data_o  <= '0;
         out_tag_o   <= '0;
         s2_addr     <= '0;
      end else begin
         if (s1_adv) begin
            out_data_o <= s1_op;
            out_tag_o  <= s1_tag;
            s2_addr    <= s1_addr;
         end else if (s2_stall) begin
            for (int k = 0; k < NR_RD_PORTS; k++) begin
               if (s2_hit[k]) out_data_o[k] <= s2_op[k];
            end
         end

         if (flush_i)          out_valid_o <= 1'b0;
         else if (s1_adv)      out_valid_o <= 1'b1;
         else if (out_ready_i) out_valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_read_stage.sv
// Bench for regfile_read_stage: BRAM model plus a scoreboard that expects each
// operand to equal the architectural register value at the output handshake.
module tb_regfile_read_stage;

   localparam int DW = 32;
   localparam int NW = 32;
   localparam int AW = 5;
   localparam int TW = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              flush = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [1:0][AW-1:0] req_raddr = '0;
   logic [TW-1:0]     req_tag = '0;
   logic [1:0][AW-1:0] rf_raddr;
   logic [1:0][DW-1:0] rf_rdata;
   logic [1:0]        wb_we = '0;
   logic [1:0][AW-1:0] wb_waddr = '0;
   logic [1:0][DW-1:0] wb_wdata = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [1:0][DW-1:0] out_data;
   logic [TW-1:0]     out_tag;

   logic [DW-1:0]     mem [NW];
   logic              mem_clr = 1'b1;

   int checks = 0;
   int errors = 0;
   int n_out  = 0;

   typedef struct {
      logic [1:0][AW-1:0] a;
      logic [TW-1:0]      tag;
   } pend_t;
   pend_t q[$];

   always #5 clk = ~clk;

   regfile_read_stage #(
      .DATA_WIDTH(DW), .NUM_WORDS(NW), .ZERO_REG_ZERO(1'b1), .TAG_WIDTH(TW)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_raddr_i(req_raddr), .req_tag_i(req_tag),
      .rf_raddr_o(rf_raddr), .rf_rdata_i(rf_rdata),
      .wb_we_i(wb_we), .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_data_o(out_data), .out_tag_o(out_tag)
   );

   // Register file: synchronous read, old data on read-during-write, port 1 last
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < NW; i++) mem[i] <= '0;
         rf_rdata <= '0;
      end else begin
         rf_rdata[0] <= mem[rf_raddr[0]];
         rf_rdata[1] <= mem[rf_raddr[1]];
         if (wb_we[0]) mem[wb_waddr[0]] <= wb_wdata[0];
         if (wb_we[1]) mem[wb_waddr[1]] <= wb_wdata[1];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Scoreboard: mem holds every write strictly before the current cycle
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
      end else begin
         if (out_valid && out_ready) begin
            n_out++;
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_spurious_out tag=%h want=none t=%0t", out_tag, $time);
            end else begin
               pend_t p;
               p = q.pop_front();
               for (int k = 0; k < 2; k++)
                  chk("sb_data", out_data[k], (p.a[k] == '0) ? '0 : mem[p.a[k]]);
               chk("sb_tag", 32'(out_tag), 32'(p.tag));
            end
         end
         if (flush) q.delete();
         if (req_valid && req_ready) q.push_back('{req_raddr, req_tag});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int a0, input int a1, input int tag);
      req_raddr[0] = AW'(a0);
      req_raddr[1] = AW'(a1);
      req_tag      = TW'(tag);
   endtask

   task automatic set_wb(input int we, input int a0, input int d0, input int a1, input int d1);
      wb_we       = 2'(we);
      wb_waddr[0] = AW'(a0);
      wb_wdata[0] = DW'(d0);
      wb_waddr[1] = AW'(a1);
      wb_wdata[1] = DW'(d1);
   endtask

   typedef struct {
      int a0, a1, tag;
      int we_n, wa0_n, wd0_n, wa1_n, wd1_n;
      int we_n1, wa0_n1, wd0_n1, wa1_n1, wd1_n1;
      int e0, e1;
   } vec_t;

   vec_t vt [7];

   initial begin
      // a0 a1 tag | accept-cycle writes | next-cycle writes | expected
      vt[0] = '{5, 6, 'h03, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0,          'h11, 'h22};
      vt[1] = '{7, 7, 'h04, 1, 7, 'hAA, 0, 0,    0, 0, 0, 0, 0,          'hAA, 'hAA};
      vt[2] = '{8, 7, 'h05, 0, 0, 0, 0, 0,       1, 8, 'hAA, 0, 0,       'hAA, 'hAA};
      vt[3] = '{7, 8, 'h06, 3, 7, 'h1, 7, 'h2,   0, 0, 0, 0, 0,          'h2,  'hAA};
      vt[4] = '{0, 0, 'h07, 1, 0, 'hFF, 0, 0,    0, 0, 0, 0, 0,          0,    0};
      vt[5] = '{5, 0, 'h08, 0, 0, 0, 0, 0,       3, 5, 'h33, 0, 'h44,    'h33, 0};
      vt[6] = '{6, 6, 'h09, 2, 0, 0, 6, 'h66,    1, 6, 'h67, 0, 0,       'h67, 'h67};

      // Reset state
      tick(); tick();
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data0", out_data[0], 0);
      chk("rst_out_tag", 32'(out_tag), 0);
      chk("rst_req_ready", 32'(req_ready), 1);
      tick();
      mem_clr = 1'b0;
      rst_n   = 1'b1;

      // Preload through the write ports
      set_wb(3, 5, 'h11, 6, 'h22); tick();
      set_wb(3, 7, 'h77, 8, 'h88); tick();
      set_wb(3, 9, 'h99, 0, 'hFF); tick();
      set_wb(0, 0, 0, 0, 0);       tick();

      // Directed vectors, no backpressure
      foreach (vt[i]) begin
         set_req(vt[i].a0, vt[i].a1, vt[i].tag);
         req_valid = 1'b1;
         set_wb(vt[i].we_n, vt[i].wa0_n, vt[i].wd0_n, vt[i].wa1_n, vt[i].wd1_n);
         tick();
         req_valid = 1'b0;
         set_wb(vt[i].we_n1, vt[i].wa0_n1, vt[i].wd0_n1, vt[i].wa1_n1, vt[i].wd1_n1);
         tick();
         set_wb(0, 0, 0, 0, 0);
         @(negedge clk);
         chk("vec_valid", 32'(out_valid), 1);
         chk("vec_data0", out_data[0], DW'(vt[i].e0));
         chk("vec_data1", out_data[1], DW'(vt[i].e1));
         chk("vec_tag", 32'(out_tag), 32'(vt[i].tag));
         tick();
      end
      // now x5=33 x6=67 x7=2 x8=AA x9=99

      // Stall: three back-to-back requests with the consumer blocked
      out_ready = 1'b0;
      req_valid = 1'b1;
      set_req(9, 5, 'h10); tick();
      set_req(5, 6, 'h11); tick();
      set_req(6, 9, 'h12);
      @(negedge clk);
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_ready_lo", 32'(req_ready), 0);
      chk("stall_data_pre", out_data[0], 'h99);
      tick();
      set_wb(1, 9, 'h55, 0, 0);
      @(negedge clk);
      chk("stall_ready_lo2", 32'(req_ready), 0);
      tick();
      set_wb(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("stall_s2_fwd", out_data[0], 'h55);
      chk("stall_tag_hold", 32'(out_tag), 'h10);
      tick();
      out_ready = 1'b1;
      @(negedge clk);
      chk("stall_ready_hi", 32'(req_ready), 1);
      tick();
      req_valid = 1'b0;
      @(negedge clk);
      chk("drain_tag1", 32'(out_tag), 'h11);
      tick();
      @(negedge clk);
      chk("drain_tag2", 32'(out_tag), 'h12);
      tick(); tick();

      // Flush with two requests in flight
      req_valid = 1'b1;
      set_req(5, 6, 'h1A); tick();
      set_req(7, 8, 'h1B); tick();
      req_valid = 1'b0;
      flush     = 1'b1;
      @(negedge clk);
      chk("flush_ready", 32'(req_ready), 0);
      tick();
      flush     = 1'b0;
      req_valid = 1'b1;
      set_req(9, 5, 'h20);
      @(negedge clk);
      chk("flush_out_lo", 32'(out_valid), 0);
      tick();
      req_valid = 1'b0;
      @(negedge clk);
      chk("flush_no_stale", 32'(out_valid), 0);
      tick();
      @(negedge clk);
      chk("post_flush_valid", 32'(out_valid), 1);
      chk("post_flush_tag", 32'(out_tag), 'h20);
      chk("post_flush_d0", out_data[0], 'h55);
      chk("post_flush_d1", out_data[1], 'h33);
      tick(); tick();

      // Full-rate streaming: one result per cycle
      for (int i = 0; i < 40; i++) begin
         req_valid = 1'b1;
         set_req($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255));
         set_wb($urandom_range(0, 3), $urandom_range(0, 7), $urandom,
                $urandom_range(0, 7), $urandom);
         @(negedge clk);
         chk("stream_ready", 32'(req_ready), 1);
         chk("stream_raddr", 32'(rf_raddr), 32'(req_raddr));
         if (i >= 2) chk("stream_valid", 32'(out_valid), 1);
         tick();
      end
      req_valid = 1'b0;
      set_wb(0, 0, 0, 0, 0);
      tick(); tick(); tick();
      chk("stream_drained", 32'(q.size()), 0);

      // Random traffic with backpressure, flushes and a mid-stream reset
      for (int i = 0; i < 300; i++) begin
         if (i == 150) begin
            req_valid = 1'b0;
            flush     = 1'b0;
            rst_n     = 1'b0;
            @(negedge clk);
            chk("midrst_valid", 32'(out_valid), 0);
            chk("midrst_data1", out_data[1], 0);
            chk("midrst_tag", 32'(out_tag), 0);
            tick();
            rst_n = 1'b1;
            tick();
         end
         req_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 39) == 0);
         set_req($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255));
         set_wb($urandom_range(0, 3), $urandom_range(0, 7), $urandom,
                $urandom_range(0, 7), $urandom);
         tick();
      end
      req_valid = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      set_wb(0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) tick();
      chk("final_drained", 32'(q.size()), 0);
      chk("final_out_lo", 32'(out_valid), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
